conv_window_sequencer: RTL
==========================

CONV_WINDOW_SEQUENCER -- requirements
Module: conv_window_sequencer

Interface
REQ-001 SHALL have parameter IMG_W, default 8, image width in pixels (legal 3..256).
REQ-002 SHALL have parameter IMG_H, default 8, image height in rows (legal 3..256).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle frame start request.
REQ-006 SHALL have port pix_in  input  4  unsigned raster-order pixel.
REQ-007 SHALL have port pix_valid  input  1  pix_in valid.
REQ-008 SHALL have port pix_ready  output  1  sequencer accepts pixel this cycle.
REQ-009 SHALL have ports win_in2, win_in4, win_in5, win_in6, win_in8  output  4 each  cross-window taps (up, left, centre, right, down) feeding the multiply stage.
REQ-010 SHALL have port win_en  output  1  win_in* hold a new window this cycle.
REQ-011 SHALL have port stage_valid  output  1  win_en delayed one cycle; marks multiply-stage outputs valid.
REQ-012 SHALL have port busy  output  1  high in any state except IDLE.
REQ-013 SHALL have port frame_done  output  1  one-cycle end-of-frame pulse.

Function
REQ-014 SHALL implement states IDLE, FILL, RUN, FLUSH, DONE.
REQ-015 SHALL move IDLE->FILL on start; start outside IDLE SHALL be ignored.
REQ-016 SHALL drive pix_ready high only in FILL and RUN; accept = pix_valid && pix_ready; pix_valid in IDLE/FLUSH/DONE SHALL be ignored.
REQ-017 SHALL keep col (0..IMG_W-1) and row (0..IMG_H-1) counters advancing per accept only; col wraps to 0 with row+1.
REQ-018 SHALL be in FILL while row<2 and RUN while row>=2; FILL->RUN on accept of last pixel of row 1.
REQ-019 SHALL hold two line buffers of IMG_W 4-bit entries (rows r-1, r-2) plus a two-deep shift of the current row, updated on accept only.
REQ-020 SHALL, on accept of pixel (r,c) with r>=2 and c>=2, register at that edge: win_in2=(r-2,c-1), win_in4=(r-1,c-2), win_in5=(r-1,c-1), win_in6=(r-1,c), win_in8=(r,c-1), and win_en=1 for the next cycle only.
REQ-021 SHALL emit exactly (IMG_W-2)*(IMG_H-2) windows per frame; no padding or border windows.
REQ-022 SHALL hold win_in* stable when win_en=0; stage_valid SHALL equal win_en delayed one clock.
REQ-023 SHALL go RUN->FLUSH on accept of pixel (IMG_H-1, IMG_W-1); FLUSH lasts 1 cycle; DONE lasts 1 cycle with frame_done=1, coincident with final stage_valid; DONE->IDLE.
REQ-024 SHALL clear row/col counters on entering FILL; line-buffer contents need not be cleared.
REQ-025 SHALL tolerate arbitrary pix_valid gaps; window content SHALL not depend on gap timing.

Reset
REQ-026 SHALL, on rst high at any time including mid-frame, immediately force IDLE, counters 0, pix_ready=0, win_en=0, stage_valid=0, busy=0, frame_done=0, win_in*=0.
REQ-027 SHALL require a new start after rst release; partial-frame data SHALL be discarded.

Configuration
REQ-028 SHALL, with CONV_SEQ_ABORT_EN defined, add input abort (1 bit): abort high in FILL/RUN/FLUSH SHALL at next edge force IDLE, counters 0, win_en=0, frame_done not pulsed; stage_valid SHALL still follow any already-issued win_en.
REQ-029 SHALL, without CONV_SEQ_ABORT_EN, have no abort port; frames run to completion or rst.

Verification
REQ-030 IMG_W=4, IMG_H=4, pixels 0..15 back-to-back -> 4 windows; first after pixel 10: in2=1,in4=4,in5=5,in6=6,in8=9; second: 2,5,6,7,10.
REQ-031 Same frame, pix_valid toggled every other cycle -> identical 4 windows, stage_valid one cycle after each win_en.
REQ-032 Last accept at edge k -> win_en cycle k+1, stage_valid and frame_done cycle k+2, busy low cycle k+3.
REQ-033 rst asserted after 7 accepts -> all outputs 0 asynchronously; new start + 16 pixels -> exactly 4 correct windows.
REQ-034 start pulsed during RUN and pix_valid in IDLE -> no effect, pix_ready stays 0 in IDLE.
REQ-035 CONV_SEQ_ABORT_EN defined, abort after 11 accepts -> IDLE next cycle, no frame_done, 1 window total.

Source files
------------

// File: rtl/conv_seq_if.sv
// Handshake and window bus between a pixel source/window consumer and conv_window_sequencer.
// Build with CONV_SEQ_ABORT_EN defined to add the abort request.
interface conv_seq_if;
  logic       start;
  logic [3:0] pix_in;
  logic       pix_valid;
  logic       pix_ready;
  logic [3:0] win_in2;
  logic [3:0] win_in4;
  logic [3:0] win_in5;
  logic [3:0] win_in6;
  logic [3:0] win_in8;
  logic       win_en;
  logic       stage_valid;
  logic       busy;
  logic       frame_done;
`ifdef CONV_SEQ_ABORT_EN
  logic       abort;

  modport master (
    output start, pix_in, pix_valid, abort,
    input  pix_ready, win_in2, win_in4, win_in5, win_in6, win_in8,
    input  win_en, stage_valid, busy, frame_done
  );

  modport slave (
    input  start, pix_in, pix_valid, abort,
    output pix_ready, win_in2, win_in4, win_in5, win_in6, win_in8,
    output win_en, stage_valid, busy, frame_done
  );
`else
  modport master (
    output start, pix_in, pix_valid,
    input  pix_ready, win_in2, win_in4, win_in5, win_in6, win_in8,
    input  win_en, stage_valid, busy, frame_done
  );

  modport slave (
    input  start, pix_in, pix_valid,
    output pix_ready, win_in2, win_in4, win_in5, win_in6, win_in8,
    output win_en, stage_valid, busy, frame_done
  );
`endif
endinterface

// File: rtl/conv_window_sequencer.sv
// Streams a raster frame through two line buffers and issues 3x3 cross windows (interior only).
// Optional feature macro: CONV_SEQ_ABORT_EN adds a frame abort input.
module conv_window_sequencer #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic        clk,
  input  logic        rst,
  conv_seq_if.slave   bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          pix_ready_c;
  logic          busy_c;
  logic          frame_done_c;
  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          abort_now;
  logic          win_fire;

  logic [3:0] lb1 [IMG_W];   // row r-1
  logic [3:0] lb2 [IMG_W];   // row r-2
  logic [3:0] prev1_d1;      // (r-1, c-1)
  logic [3:0] prev1_d2;      // (r-1, c-2)
  logic [3:0] prev2_d1;      // (r-2, c-1)
  logic [3:0] cur_d1;        // (r,   c-1)

  assign pix_ready_c = (state == FILL) || (state == RUN);
  assign accept      = bus.pix_valid && pix_ready_c;
  assign col_last    = (col == COL_LAST);
  assign row_last    = (row == ROW_LAST);
  // RUN implies row >= 2, so only the column needs checking.
  assign win_fire    = accept && (state == RUN) && (col >= CW'(2));

`ifdef CONV_SEQ_ABORT_EN
  assign abort_now = bus.abort && ((state == FILL) || (state == RUN) || (state == FLUSH));
`else
  assign abort_now = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    busy_c       = 1'b1;
    frame_done_c = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.start) state_nxt = FILL;
      end
      FILL: begin
        if (accept && col_last && (row == RW'(1))) state_nxt = RUN;
      end
      RUN: begin
        if (accept && col_last && row_last) state_nxt = FLUSH;
      end
      FLUSH: begin
        state_nxt = DONE;
      end
      DONE: begin
        frame_done_c = 1'b1;
        state_nxt    = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (abort_now) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (abort_now || ((state == IDLE) && bus.start)) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Line buffers are never cleared: every tap is overwritten by the new frame before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[col] <= lb1[col];
      lb1[col] <= bus.pix_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev1_d1 <= '0;
      prev1_d2 <= '0;
      prev2_d1 <= '0;
      cur_d1   <= '0;
    end else if (accept) begin
      prev1_d1 <= lb1[col];
      prev1_d2 <= prev1_d1;
      prev2_d1 <= lb2[col];
      cur_d1   <= bus.pix_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.win_in2     <= '0;
      bus.win_in4     <= '0;
      bus.win_in5     <= '0;
      bus.win_in6     <= '0;
      bus.win_in8     <= '0;
      bus.win_en      <= 1'b0;
      bus.stage_valid <= 1'b0;
    end else begin
      bus.stage_valid <= bus.win_en;
      bus.win_en      <= win_fire && !abort_now;
      if (win_fire && !abort_now) begin
        bus.win_in2 <= prev2_d1;
        bus.win_in4 <= prev1_d2;
        bus.win_in5 <= prev1_d1;
        bus.win_in6 <= lb1[col];
        bus.win_in8 <= cur_d1;
      end
    end
  end

  assign bus.pix_ready  = pix_ready_c;
  assign bus.busy       = busy_c;
  assign bus.frame_done = frame_done_c;
endmodule
